lcd_msg_arbiter: RTL
====================

// Module: lcd_msg_arbiter
// PURPOSE
//  Shares the single 16x2 LCD message path between NREQ requesters (e.g. vote keypad, status, errors).
//  Arbitrates round-robin and latches the winner's message selector onto oMSG (feeds LCD_CONTENT).
//  Pulses an active-low force-reset into LCD_Reset_Delay, then waits for LCD re-init.
//  Holds the message for a minimum display time, then acks the requester.
// PARAMETERS
//  NREQ        3           number of requesters (2..8)
//  MSG_W       3           message selector width
//  DEFAULT_MSG 0           oMSG value after reset
//  RST_CYC     4           oFORCE_RESET_N low duration, cycles (>=1)
//  RDY_TO      10_000_000  max cycles to wait for iLCD_READY before timeout (>=1)
//  HOLD_CYC    50_000_000  minimum display time after ready, cycles (>=1; 0 treated as 1)
// PORTS
//  iCLK            in   1            system clock (CLOCK_50)
//  iRST            in   1            asynchronous reset, active-high
//  iREQ            in   NREQ         level request per requester
//  iMSG            in   NREQ*MSG_W   message selectors, requester i at [i*MSG_W +: MSG_W]
//  iLCD_READY      in   1            oRESET of LCD_Reset_Delay (1 = LCD init released)
//  oMSG            out  MSG_W        selector to LCD_CONTENT
//  oFORCE_RESET_N  out  1            to LCD_Reset_Delay FORCE_RESET, active-low pulse
//  oGNT            out  NREQ         one-hot done/ack pulse, 1 cycle
//  oBUSY           out  1            1 in any state other than IDLE
//  oTIMEOUT        out  1            sticky: a ready-wait timed out
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, oMSG=DEFAULT_MSG, oFORCE_RESET_N=1, oGNT=0, oBUSY=0,
//   oTIMEOUT=0, rr pointer=0, all counters 0. A reset mid-operation abandons the request; no oGNT.
//  FSM: IDLE -> RESET -> WAIT_RDY -> HOLD -> ACK -> IDLE.
//  IDLE: if |iREQ at edge k, winner = first set bit searching from ptr upward, wrapping mod NREQ.
//   At edge k: oMSG <= iMSG slice of winner, oFORCE_RESET_N <= 0, oBUSY <= 1, go RESET.
//   iMSG is sampled only at this edge; later changes are ignored until the next grant.
//  RESET: oFORCE_RESET_N stays low exactly RST_CYC cycles, then returns to 1; go WAIT_RDY.
//  WAIT_RDY: wait for iLCD_READY to be seen 0 at least once, then 1 (rising after the forced reset).
//   If iLCD_READY was already 0 during RESET, that counts as the 0 sample. On rising -> HOLD.
//   Counter runs from WAIT_RDY entry; at RDY_TO cycles without a rising edge: oTIMEOUT <= 1, go HOLD.
//  HOLD: count HOLD_CYC cycles, then ACK. No preemption; new requests wait.
//  ACK: oGNT[winner]=1 for exactly one cycle; ptr <= (winner+1) mod NREQ; go IDLE (oBUSY=0 in IDLE).
//  Requester must drop iREQ in the cycle after oGNT. If it is still high, it is a new request, but
//   other pending requesters win first because of the ptr advance.
//  Redisplaying the same message value is still a full cycle (force-reset, ready wait, hold).
//  oTIMEOUT clears only on iRST. Minimum IDLE-to-IDLE latency: 1+RST_CYC+ready+HOLD_CYC+1 cycles.
//  Counter widths: $clog2 of the largest of RST_CYC, RDY_TO, HOLD_CYC, plus 1 bit; no wrap-around.
// TESTING (sim params: RST_CYC=2, RDY_TO=16, HOLD_CYC=8, NREQ=3, MSG_W=3)
//  1 iREQ=001, iMSG0=3; model drops READY for 3 cycles after the force pulse -> oMSG=3 one edge
//    later, FORCE_N low 2 cycles, 8 HOLD cycles after READY rises, then oGNT=001 for 1 cycle.
//  2 iREQ=111 held, each requester drops on its grant -> grants 001,010,100 in that order.
//    Re-request all -> 001,010,100 again.
//  3 iLCD_READY stuck 0 -> oTIMEOUT=1 16 cycles after WAIT_RDY entry, then HOLD 8 cycles, oGNT=001.
//    oTIMEOUT stays 1 through later requests.
//  4 iRST pulsed during HOLD -> same cycle: oMSG=0, FORCE_N=1, oBUSY=0, oGNT=0; no oGNT follows.
//  5 iMSG0 changed 3->5 during HOLD -> oMSG stays 3 until the next grant.
//  6 iREQ0 held high past its grant with iREQ2 pending -> next grant is 100, then 001.

Source files
------------

// File: rtl/lcd_msg_arbiter_if.sv
// Request/message/LCD-handshake bundle between requesters, the LCD message arbiter and the LCD.
// Pure wiring: no state and no added latency.
// The master side drives requests, selectors and LCD ready; the slave (arbiter) drives the rest.
interface lcd_msg_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int MSG_W = 3
);
  logic [NREQ-1:0]       iREQ;
  logic [NREQ*MSG_W-1:0] iMSG;
  logic                  iLCD_READY;
  logic [MSG_W-1:0]      oMSG;
  logic                  oFORCE_RESET_N;
  logic [NREQ-1:0]       oGNT;
  logic                  oBUSY;
  logic                  oTIMEOUT;

  modport master (
    output iREQ, iMSG, iLCD_READY,
    input  oMSG, oFORCE_RESET_N, oGNT, oBUSY, oTIMEOUT
  );

  modport slave (
    input  iREQ, iMSG, iLCD_READY,
    output oMSG, oFORCE_RESET_N, oGNT, oBUSY, oTIMEOUT
  );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// Round-robin owner of the shared LCD message path: latches the winner's selector, forces an LCD re-init.
// Latency: grant edge, RST_CYC force-low cycles, ready wait (<= RDY_TO), HOLD_CYC hold, 1-cycle ack.
// No preemption: requests arriving while busy simply wait in iREQ until the arbiter returns to IDLE.
module lcd_msg_arbiter #(
  parameter int NREQ        = 3,
  parameter int MSG_W       = 3,
  parameter int DEFAULT_MSG = 0,
  parameter int RST_CYC     = 4,
  parameter int RDY_TO      = 10_000_000,
  parameter int HOLD_CYC    = 50_000_000
) (
  input  logic               iCLK,
  input  logic               iRST,
  lcd_msg_arbiter_if.slave   bus
);

  // Degenerate zero settings behave as a single cycle so every phase is always visited.
  localparam int RST_EFF  = (RST_CYC  < 1) ? 1 : RST_CYC;
  localparam int RDY_EFF  = (RDY_TO   < 1) ? 1 : RDY_TO;
  localparam int HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int MAX_AB   = (RST_EFF > RDY_EFF) ? RST_EFF : RDY_EFF;
  localparam int MAX_CYC  = (MAX_AB > HOLD_EFF) ? MAX_AB : HOLD_EFF;
  localparam int CNT_W    = $clog2(MAX_CYC) + 1;
  localparam int PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Terminal counts: each phase counter starts at 0 on phase entry.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_EFF - 1);
  localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(RDY_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_RDY,
    ST_HOLD,
    ST_ACK
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [MSG_W-1:0]  msg, msg_nxt;
  logic              force_n, force_n_nxt;
  logic [NREQ-1:0]   gnt, gnt_nxt;
  logic              busy, busy_nxt;
  logic              timeout, timeout_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [PTR_W-1:0]  winner, winner_nxt;
  logic              seen_low, seen_low_nxt;

  // Round-robin search result, valid whenever any request is present.
  logic              found;
  logic [PTR_W-1:0]  pick;
  int                idx;
  int                pick_base;

  // Find the first requester at or above ptr, wrapping around modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && bus.iREQ[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    pick_base = int'(pick) * MSG_W;
  end

  // Next-state and next-output logic; every register holds unless a phase changes it.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    msg_nxt      = msg;
    force_n_nxt  = force_n;
    gnt_nxt      = '0;
    busy_nxt     = busy;
    timeout_nxt  = timeout;
    ptr_nxt      = ptr;
    winner_nxt   = winner;
    seen_low_nxt = seen_low;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (found) begin
          // The selector is captured only here; later iMSG changes wait for the next grant.
          state_nxt    = ST_RESET;
          winner_nxt   = pick;
          msg_nxt      = bus.iMSG[pick_base +: MSG_W];
          force_n_nxt  = 1'b0;
          busy_nxt     = 1'b1;
          cnt_nxt      = '0;
          seen_low_nxt = 1'b0;
        end
      end

      ST_RESET: begin
        // A low ready seen while the force pulse is active already counts as the 0 sample.
        if (!bus.iLCD_READY) begin
          seen_low_nxt = 1'b1;
        end
        if (cnt == RST_LAST) begin
          force_n_nxt = 1'b1;
          state_nxt   = ST_WAIT_RDY;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_WAIT_RDY: begin
        if (bus.iLCD_READY && seen_low) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          if (!bus.iLCD_READY) begin
            seen_low_nxt = 1'b1;
          end
          if (cnt == RDY_LAST) begin
            // Give up on the LCD but still show the message for the full hold time.
            timeout_nxt = 1'b1;
            state_nxt   = ST_HOLD;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_ACK;
          cnt_nxt   = '0;
          gnt_nxt   = NREQ'(1) << winner;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_ACK: begin
        // Advance past the winner so a still-asserted request yields to the others.
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
        ptr_nxt   = (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
      end

      default: begin
        state_nxt   = ST_IDLE;
        busy_nxt    = 1'b0;
        force_n_nxt = 1'b1;
        cnt_nxt     = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight without an ack.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      msg      <= MSG_W'(DEFAULT_MSG);
      force_n  <= 1'b1;
      gnt      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      winner   <= '0;
      seen_low <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      msg      <= msg_nxt;
      force_n  <= force_n_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      ptr      <= ptr_nxt;
      winner   <= winner_nxt;
      seen_low <= seen_low_nxt;
    end
  end

  assign bus.oMSG           = msg;
  assign bus.oFORCE_RESET_N = force_n;
  assign bus.oGNT           = gnt;
  assign bus.oBUSY          = busy;
  assign bus.oTIMEOUT       = timeout;

endmodule
